// File: rtl/sram_fifo_ctrl_if.sv
// Push/pop stream bundle for sram_fifo_ctrl: the user side drives through master, the FIFO through slave.
interface sram_fifo_ctrl_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic [ADDR_WIDTH:0]   count;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, count
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, count
    );
endinterface

// File: rtl/sram_fifo_ctrl.sv
// First-word-fall-through FIFO on a 1W1R SRAM macro with a 2-entry skid buffer hiding read latency.
// Define SRAM_FIFO_HWM_EN to add the hwm_clr/hwm high-water-mark tracker.
module sram_fifo_ctrl #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_WMASKS = 2,
    localparam int DEPTH = 1 << ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
`ifdef SRAM_FIFO_HWM_EN
    input  logic                  hwm_clr,
    output logic [ADDR_WIDTH:0]   hwm,
`endif
    sram_fifo_ctrl_if.slave       bus,
    output logic                  sram_csb0,
    output logic [NUM_WMASKS-1:0] sram_wmask0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    output logic                  sram_csb1,
    output logic [ADDR_WIDTH-1:0] sram_addr1,
    input  logic [DATA_WIDTH-1:0] sram_dout1
);
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);

    logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr, addr0_q;
    logic [DATA_WIDTH-1:0] din0_q;
    logic [ADDR_WIDTH:0]   mem_count, total;
    logic                  rd_inflight;
    logic [1:0]            ob_count, ob_count_nxt;
    logic [DATA_WIDTH-1:0] ob0, ob1, ob0_nxt, ob1_nxt;
    logic                  push, pop, rd_issue;

    // Reset is folded into in_ready so nothing can be pushed while rst is held.
    assign bus.in_ready  = !rst && (mem_count < DEPTH_C);
    assign push          = bus.in_valid && bus.in_ready;
    assign bus.out_valid = (ob_count != 2'd0);
    assign pop           = bus.out_valid && bus.out_ready;
    assign bus.out_data  = ob0;

    // Issue a read when the skid buffer has room for the returning word, counting one in flight.
    assign rd_issue = (mem_count != '0) &&
                      (((3'(ob_count) + 3'(rd_inflight)) < 3'd2) || pop);

    assign total     = mem_count + (ADDR_WIDTH+1)'(rd_inflight) + (ADDR_WIDTH+1)'(ob_count);
    assign bus.count = total;

    assign sram_csb0   = !push;
    assign sram_wmask0 = '1;
    assign sram_addr0  = push ? wr_ptr : addr0_q;
    assign sram_din0   = push ? bus.in_data : din0_q;
    assign sram_csb1   = !rd_issue;
    assign sram_addr1  = rd_ptr;

    always_comb begin
        ob0_nxt      = ob0;
        ob1_nxt      = ob1;
        ob_count_nxt = ob_count;
        case ({pop, rd_inflight})
            2'b10: begin
                ob0_nxt      = ob1;
                ob_count_nxt = ob_count - 2'd1;
            end
            2'b01: begin
                if (ob_count == 2'd0) ob0_nxt = sram_dout1;
                else                  ob1_nxt = sram_dout1;
                ob_count_nxt = ob_count + 2'd1;
            end
            2'b11: begin
                if (ob_count == 2'd1) begin
                    ob0_nxt = sram_dout1;
                end else begin
                    ob0_nxt = ob1;
                    ob1_nxt = sram_dout1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            mem_count   <= '0;
            rd_inflight <= 1'b0;
            ob_count    <= 2'd0;
            ob0         <= '0;
        end else begin
            if (push)     wr_ptr <= wr_ptr + 1'b1;
            if (rd_issue) rd_ptr <= rd_ptr + 1'b1;
            case ({push, rd_issue})
                2'b10:   mem_count <= mem_count + 1'b1;
                2'b01:   mem_count <= mem_count - 1'b1;
                default: ;
            endcase
            rd_inflight <= rd_issue;
            ob_count    <= ob_count_nxt;
            ob0         <= ob0_nxt;
        end
    end

    // Second skid entry and the write-port hold registers carry data only.
    always_ff @(posedge clk) begin
        ob1 <= ob1_nxt;
        if (push) begin
            addr0_q <= wr_ptr;
            din0_q  <= bus.in_data;
        end
    end

`ifdef SRAM_FIFO_HWM_EN
    logic [ADDR_WIDTH:0] hwm_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                hwm_q <= '0;
        else if (hwm_clr)       hwm_q <= total;
        else if (total > hwm_q) hwm_q <= total;
    end

    assign hwm = hwm_q;
`endif
endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Directed bench for sram_fifo_ctrl with a behavioural 1W1R SRAM macro and an in-order word queue.
module tb_sram_fifo_ctrl;
    localparam int DW = 64;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          sram_csb0, sram_csb1;
    logic [1:0]    sram_wmask0;
    logic [AW-1:0] sram_addr0, sram_addr1;
    logic [DW-1:0] sram_din0, sram_dout1;
`ifdef SRAM_FIFO_HWM_EN
    logic          hwm_clr;
    logic [AW:0]   hwm;
`endif

    int            vectors = 0;
    int            miscompares = 0;
    logic [DW-1:0] q[$];
    logic [DW-1:0] mem[1<<AW];

    always #5 clk = ~clk;

    sram_fifo_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    sram_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_WMASKS(2)) dut (
        .clk         (clk),
        .rst         (rst),
`ifdef SRAM_FIFO_HWM_EN
        .hwm_clr     (hwm_clr),
        .hwm         (hwm),
`endif
        .bus         (bus),
        .sram_csb0   (sram_csb0),
        .sram_wmask0 (sram_wmask0),
        .sram_addr0  (sram_addr0),
        .sram_din0   (sram_din0),
        .sram_csb1   (sram_csb1),
        .sram_addr1  (sram_addr1),
        .sram_dout1  (sram_dout1)
    );

    // Macro model: both ports latch at the clock edge, read data is registered.
    always @(posedge clk) begin
        if (!sram_csb0) mem[sram_addr0] <= sram_din0;
        if (!sram_csb1) sram_dout1 <= mem[sram_addr1];
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_n(input int n, input logic [DW-1:0] base);
        for (int i = 0; i < n; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = base + DW'(i);
            #1;
            chk("push_ready", bus.in_ready, 1'b1);
            q.push_back(bus.in_data);
            cyc();
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic drain(input int n);
        logic [DW-1:0] exp;
        bus.out_ready = 1'b1;
        #1;
        for (int i = 0; i < n; i++) begin
            for (int t = 0; t < 20 && !bus.out_valid; t++) cyc();
            chk("drain_valid", bus.out_valid, 1'b1);
            exp = (q.size() != 0) ? q.pop_front() : '1;
            chk("drain_data", bus.out_data, exp);
            cyc();
        end
        bus.out_ready = 1'b0;
        #1;
    endtask

    // Scoreboard work for one cycle at the settle point before the edge.
    task automatic observe();
        logic [DW-1:0] exp;
        chk("no_rw_collision", (!sram_csb0 && !sram_csb1 && sram_addr0 == sram_addr1), 1'b0);
        chk("ob_count_le2", (dut.ob_count <= 2'd2), 1'b1);
        if (bus.in_valid && bus.in_ready) q.push_back(bus.in_data);
        if (bus.out_valid && bus.out_ready) begin
            exp = (q.size() != 0) ? q.pop_front() : '1;
            chk("stream_order", bus.out_data, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int sent, got, first, last, left;
        rst           = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 64'hDEAD;
        bus.out_ready = 1'b0;
`ifdef SRAM_FIFO_HWM_EN
        hwm_clr       = 1'b0;
`endif
        cyc();
        chk("rst_in_ready", bus.in_ready, 1'b0);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_count", bus.count, 0);
        chk("rst_csb0", sram_csb0, 1'b1);
        chk("rst_csb1", sram_csb1, 1'b1);
        bus.in_valid = 1'b0;
        cyc();
        rst = 1'b0;
        cyc();

        // Single word: write issue, 3-cycle fall-through latency.
        bus.in_valid = 1'b1;
        bus.in_data  = 64'hA5A5_0000_0000_0001;
        #1;
        chk("t1_in_ready", bus.in_ready, 1'b1);
        chk("t1_csb0", sram_csb0, 1'b0);
        chk("t1_addr0", sram_addr0, 0);
        chk("t1_din0", sram_din0, 64'hA5A5_0000_0000_0001);
        chk("t1_wmask0", sram_wmask0, 2'b11);
        cyc();
        bus.in_valid = 1'b0;
        #1;
        chk("t1_c1_count", bus.count, 1);
        chk("t1_c1_out_valid", bus.out_valid, 1'b0);
        chk("t1_c1_csb1", sram_csb1, 1'b0);
        chk("t1_c1_addr1", sram_addr1, 0);
        cyc();
        chk("t1_c2_count", bus.count, 1);
        chk("t1_c2_out_valid", bus.out_valid, 1'b0);
        chk("t1_c2_csb0", sram_csb0, 1'b1);
        cyc();
        chk("t1_c3_out_valid", bus.out_valid, 1'b1);
        chk("t1_c3_out_data", bus.out_data, 64'hA5A5_0000_0000_0001);
        chk("t1_c3_count", bus.count, 1);
        bus.out_ready = 1'b1;
        cyc();
        bus.out_ready = 1'b0;
        #1;
        chk("t1_empty_count", bus.count, 0);
        chk("t1_empty_valid", bus.out_valid, 1'b0);

        // Full: DEPTH + 2 words accepted, the next is refused.
        push_n(34, 64'h0000_0200_0000_0000);
        bus.in_valid = 1'b1;
        bus.in_data  = 64'h0000_0BAD_0000_0000;
        #1;
        chk("full_in_ready", bus.in_ready, 1'b0);
        chk("full_count", bus.count, 34);
        cyc();
        chk("full_count_hold", bus.count, 34);
        bus.in_valid = 1'b0;
        drain(34);
        chk("full_drained_count", bus.count, 0);

        // Streaming 100 words across pointer wrap.
        sent = 0; got = 0; first = -1; last = -1;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 400 && got < 100; c++) begin
            bus.in_valid = (sent < 100);
            bus.in_data  = 64'h3300_0000_0000_0000 + DW'(sent);
            #1;
            if (bus.in_valid && bus.in_ready) sent++;
            if (bus.out_valid) begin
                if (got == 0) first = c;
                last = c;
                got++;
            end
            observe();
            cyc();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        #1;
        chk("stream_got", got, 100);
        chk("stream_first_cycle", first, 3);
        chk("stream_span", last - first, 99);
        chk("stream_count", bus.count, 0);

        // Random backpressure with continuous pushes.
        sent = 0;
        for (int c = 0; c < 200; c++) begin
            bus.in_valid  = 1'b1;
            bus.in_data   = 64'h4400_0000_0000_0000 + DW'(sent);
            bus.out_ready = 1'($urandom_range(0, 1));
            #1;
            if (bus.in_ready) sent++;
            observe();
            cyc();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        #1;
        chk("rand_count", bus.count, q.size());
        left = q.size();
        drain(left);
        chk("rand_drained", bus.count, 0);

        // Asynchronous reset while 10 words are held.
        push_n(10, 64'h5500_0000_0000_0000);
        cyc();
        cyc();
        chk("pre_rst_count", bus.count, 10);
        bus.in_valid = 1'b1;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", bus.out_valid, 1'b0);
        chk("arst_count", bus.count, 0);
        chk("arst_csb0", sram_csb0, 1'b1);
        chk("arst_csb1", sram_csb1, 1'b1);
        chk("arst_in_ready", bus.in_ready, 1'b0);
`ifdef SRAM_FIFO_HWM_EN
        chk("arst_hwm", hwm, 0);
`endif
        #2;
        rst = 1'b0;
        bus.in_valid = 1'b0;
        q.delete();
        cyc();
        bus.in_valid = 1'b1;
        bus.in_data  = 64'h6666_0000_0000_0042;
        #1;
        chk("post_rst_csb0", sram_csb0, 1'b0);
        chk("post_rst_addr0", sram_addr0, 0);
        q.push_back(bus.in_data);
        cyc();
        bus.in_valid = 1'b0;
        drain(1);
        chk("post_rst_count", bus.count, 0);

`ifdef SRAM_FIFO_HWM_EN
        hwm_clr = 1'b1;
        cyc();
        hwm_clr = 1'b0;
        #1;
        chk("hwm_clr_empty", hwm, 0);
        push_n(20, 64'h7700_0000_0000_0000);
        cyc();
        chk("hwm_fill_count", bus.count, 20);
        drain(20);
        chk("hwm_peak", hwm, 20);
        chk("hwm_drained_count", bus.count, 0);
        hwm_clr = 1'b1;
        cyc();
        hwm_clr = 1'b0;
        #1;
        chk("hwm_after_clr", hwm, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
